// File: rtl/video_pattern_pkg.sv
// Shared constants for the video pattern generator: TRS words, blanking
// levels, 75% colour bar table and the XYZ protection-word helper.
package video_pattern_pkg;

    localparam logic [9:0] TRS_ONES  = 10'h3FF;
    localparam logic [9:0] TRS_ZEROS = 10'h000;
    localparam logic [9:0] BLANK_Y   = 10'h040;
    localparam logic [9:0] BLANK_C   = 10'h200;

    localparam int NUM_BARS = 8;

    // Element [0] is white, [7] is black.
    localparam logic [NUM_BARS-1:0][9:0] BAR_Y = {
        10'd64,  10'd139, 10'd260, 10'd335,
        10'd450, 10'd525, 10'd646, 10'd721
    };
    localparam logic [NUM_BARS-1:0][9:0] BAR_CB = {
        10'd512, 10'd848, 10'd448, 10'd771,
        10'd253, 10'd589, 10'd176, 10'd512
    };
    localparam logic [NUM_BARS-1:0][9:0] BAR_CR = {
        10'd512, 10'd481, 10'd848, 10'd817,
        10'd207, 10'd176, 10'd543, 10'd512
    };

    typedef enum logic [1:0] {
        PH_EAV,
        PH_HBLANK,
        PH_SAV,
        PH_ACTIVE
    } phase_t;

    // Fourth TRS word with its protection bits.
    function automatic logic [9:0] trs_xyz(input logic f,
                                           input logic v,
                                           input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
    endfunction

endpackage

// File: rtl/video_raster_cnt.sv
// Raster position counters (hc, vc) advanced by cen_i, plus line-phase,
// TRS word index and h/v blanking decodes of the current position.
// Ports: clk_i, rst_n_i, cen_i in; hc_o, vc_o, phase_o, trs_idx_o, h_o, v_o out.
module video_raster_cnt
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_TOTAL  = 2200,
    parameter int V_ACTIVE = 1080,
    parameter int V_TOTAL  = 1125
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cen_i,
    output logic [$clog2(H_TOTAL)-1:0] hc_o,
    output logic [$clog2(V_TOTAL)-1:0] vc_o,
    output logic [1:0]                 phase_o,
    output logic [1:0]                 trs_idx_o,
    output logic                       h_o,
    output logic                       v_o
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int HB = H_TOTAL - H_ACTIVE;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HB_L    = HW'(HB);
    localparam logic [HW-1:0] SAV_L   = HW'(HB - 4);
    localparam logic [HW-1:0] EAV_END = HW'(4);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VA_L    = VW'(V_ACTIVE);
    // SAV need not start on a multiple of 4; index is taken mod 4.
    localparam logic [1:0]    SAV_PH  = SAV_L[1:0];

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hc <= '0;
            vc <= '0;
        end else if (cen_i) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    always_comb begin
        phase_o   = PH_ACTIVE;
        trs_idx_o = 2'd0;
        if (hc < EAV_END) begin
            phase_o   = PH_EAV;
            trs_idx_o = hc[1:0];
        end else if (hc < SAV_L) begin
            phase_o   = PH_HBLANK;
        end else if (hc < HB_L) begin
            phase_o   = PH_SAV;
            trs_idx_o = hc[1:0] - SAV_PH;
        end
    end

    assign hc_o = hc;
    assign vc_o = vc;
    assign h_o  = (hc < HB_L);
    assign v_o  = (vc >= VA_L);

endmodule

// File: rtl/video_pattern_gen.sv
// Progressive raster source with SAV/EAV, 75% bars or flat colour, 4:2:2.
// Ports: clk_i, rst_n_i, cen_i, pattern_sel_i, colour_i in; fvht_o, video_o, sof_o out.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_TOTAL  = 2200,
    parameter int V_ACTIVE = 1080,
    parameter int V_TOTAL  = 1125
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cen_i,
    input  logic        pattern_sel_i,
    input  logic [29:0] colour_i,
    output logic [3:0]  fvht_o,
    output logic [19:0] video_o,
    output logic        sof_o
);

    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);
    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BW    = $clog2(BAR_W);

    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic [1:0]    phase_raw;
    phase_t        phase;
    logic [1:0]    trs_idx;
    logic          h;
    logic          v;
    logic          frame_start;

    logic          pat_flat;
    logic [29:0]   pat_colour;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic          cb_phase;

    logic [9:0]    trs_word;
    logic [9:0]    nxt_y;
    logic [9:0]    nxt_c;
    logic          nxt_t;

    video_raster_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .cen_i     (cen_i),
        .hc_o      (hc),
        .vc_o      (vc),
        .phase_o   (phase_raw),
        .trs_idx_o (trs_idx),
        .h_o       (h),
        .v_o       (v)
    );

    assign phase       = phase_t'(phase_raw);
    assign frame_start = (hc == '0) && (vc == '0);
    // Bar width is even, so the low bit of the in-bar count gives p parity.
    assign cb_phase    = ~bar_cnt[0];

    // Pattern is frozen for a whole frame, sampled on its first word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pat_flat   <= 1'b0;
            pat_colour <= '0;
        end else if (cen_i && frame_start) begin
            pat_flat   <= pattern_sel_i;
            pat_colour <= colour_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (cen_i) begin
            if (phase == PH_ACTIVE) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 1'b1;
                end
            end else begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end
        end
    end

    always_comb begin
        trs_word = TRS_ZEROS;
        nxt_y    = BLANK_Y;
        nxt_c    = BLANK_C;
        nxt_t    = 1'b0;
        unique case (phase)
            PH_EAV, PH_SAV: begin
                unique case (trs_idx)
                    2'd0: begin
                        trs_word = TRS_ONES;
                        nxt_t    = 1'b1;
                    end
                    2'd3: trs_word = trs_xyz(1'b0, v, phase == PH_EAV);
                    default: trs_word = TRS_ZEROS;
                endcase
                nxt_y = trs_word;
                nxt_c = trs_word;
            end
            PH_HBLANK: begin
            end
            PH_ACTIVE: begin
                if (!v) begin
                    if (pat_flat) begin
                        nxt_y = pat_colour[29:20];
                        nxt_c = cb_phase ? pat_colour[19:10]
                                         : pat_colour[9:0];
                    end else begin
                        nxt_y = BAR_Y[bar_idx];
                        nxt_c = cb_phase ? BAR_CB[bar_idx]
                                         : BAR_CR[bar_idx];
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            video_o <= {BLANK_Y, BLANK_C};
            fvht_o  <= 4'b0110;
            sof_o   <= 1'b0;
        end else if (cen_i) begin
            video_o <= {nxt_y, nxt_c};
            fvht_o  <= {1'b0, v, h, nxt_t};
            sof_o   <= frame_start;
        end
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Source end of the 20-bit {luma, chroma} video and 4-bit fvht timing bus that the video unit under test consumes. It generates a progressive raster with embedded SAV/EAV timing reference words. Active lines carry either 75% colour bars or a flat user colour, as 4:2:2 Y/C words. It drives the `vdat_bars_i`/`vdat_colour_i` and `fvht_i` inputs of downstream video blocks, one word per enabled clock.

## Interface
- `H_ACTIVE`, default 1920: active words per line; must be a multiple of 16.
- `H_TOTAL`, default 2200: total words per line; `H_TOTAL - H_ACTIVE` must be at least 8.
- `V_ACTIVE`, default 1080: active lines per frame.
- `V_TOTAL`, default 1125: total lines per frame.

- `clk_i`, in, 1: clock.
- `rst_n_i`, in, 1: reset, asynchronous, active-low.
- `cen_i`, in, 1: clock enable. All state advances only when high.
- `pattern_sel_i`, in, 1: 0 selects colour bars; 1 selects flat colour.
- `colour_i`, in, 30: flat colour as {Y[29:20], Cb[19:10], Cr[9:0]}.
- `fvht_o`, out, 4: {f, v, h, t} timing flags.
- `video_o`, out, 20: {Y[19:10], C[9:0]}.
- `sof_o`, out, 1: high for one enabled word, on the first word of line 0.

## Operation
- Counters:
  - `hc` runs 0..H_TOTAL-1. `vc` runs 0..V_TOTAL-1 and increments when `hc` wraps.
  - Let HB = H_TOTAL - H_ACTIVE.
- Line layout by `hc`:
  - 0..3: EAV.
  - 4..HB-5: horizontal blanking.
  - HB-4..HB-1: SAV.
  - HB..H_TOTAL-1: active.
- Flags:
  - f = 0 always (progressive).
  - v = (vc >= V_ACTIVE).
  - h = (hc < HB).
  - t = 1 only on the first word (0x3FF) of each EAV and SAV.
- TRS words:
  - Both Y and C lanes carry 0x3FF, 0x000, 0x000, then XYZ.
  - XYZ = {1, F, V, H, V^H, F^H, F^V, F^V^H, 2'b00}.
  - With F=0 this gives: EAV active 0x274, SAV active 0x200, EAV blanked 0x2D8, SAV blanked 0x2AC.
- Blanking data (horizontal blanking words and all non-TRS words of v=1 lines): Y=0x040, C=0x200.
- Active words, v=0 lines:
  - Let p = hc - HB.
  - C carries Cb when p is even and Cr when p is odd; both are taken from the value for the Cb/Cr pair.
  - Bar index advances every H_ACTIVE/8 words. Use a bar-width counter, not a divider.
- Bars, in order as Y/Cb/Cr:
  - white 721/512/512
  - yellow 646/176/543
  - cyan 525/589/176
  - green 450/253/207
  - magenta 335/771/817
  - red 260/448/848
  - blue 139/848/481
  - black 64/512/512
- Pattern latch: `pattern_sel_i` and `colour_i` are sampled only on the enabled cycle where hc=0 and vc=0. Changes mid-frame take effect at the next frame.

## Timing
- All outputs are registered.
- Each enabled cycle: outputs take the word decoded from the current (hc, vc), then the counters advance.
- Latency from counter to output is 1 enabled cycle.
- When `cen_i` is low, outputs and counters hold.
- Reset values:
  - hc=0, vc=0.
  - `video_o` = {0x040, 0x200}.
  - `fvht_o` = 4'b0110.
  - `sof_o` = 0.
  - Latched pattern = bars.
- First enabled cycle after reset release outputs: EAV word 0 of line 0, 0x3FF/0x3FF, `fvht_o` = 4'b0011, `sof_o` = 1.
- Wrap: at hc=H_TOTAL-1 and vc=V_TOTAL-1, both counters return to 0 on the same enabled cycle.
- Reset asserted mid-frame: all state returns to reset values immediately. No partial line is completed.
- `sof_o` and t coincide on the line 0 EAV first word.

## Structure
- Package `video_pattern_pkg` holds:
  - the bar Y/Cb/Cr constant arrays;
  - the TRS constants 0x3FF/0x000;
  - blanking levels 0x040/0x200;
  - a `function` computing XYZ from (f, v, h).
- Optional sub-module `video_raster_cnt`: hc/vc counters with a cen input, exporting the position and the h/v/TRS-phase decodes.
- The top level does pattern select, bar sequencing and output registers.

## Test plan
- Reset, then cen constant high, small raster (H_ACTIVE=64, H_TOTAL=80, V_ACTIVE=4, V_TOTAL=6):
  - first 4 words are 3FF/000/000/274 with t=1 only on word 0;
  - SAV at hc 12..15 ends with 0x200.
- Same raster, lines 4 and 5: EAV ends 0x2D8, SAV ends 0x2AC, v=1, active region all Y=0x040 and C=0x200.
- Bars check:
  - active word p=0 gives Y=721, C=512;
  - p=8 gives Y=646, C=176;
  - p=9 gives Y=646, C=543;
  - p=56 gives Y=64.
- `cen_i` toggled 1-0-1 randomly: output sequence identical to the cen-always-high sequence with duplicates removed; no word is skipped.
- Switch `pattern_sel_i` to 1 with `colour_i` = {300, 400, 600} mid-frame:
  - current frame stays bars;
  - next frame active words are Y=300 with C alternating 400/600;
  - `sof_o` pulses once per frame.
- Assert `rst_n_i` at hc=30, vc=2: outputs go to reset values without a clock edge; after release, output restarts at the line 0 EAV.
